// File: rtl/inst_buffer_if.sv
// Bundle of fetch-return, issue and status signals between the icache return path,
// the instruction buffer and the dual-issue stage.
interface inst_buffer_if;
    logic        flush;
    logic        fetch_valid1;
    logic        fetch_valid2;
    logic [31:0] fetch_inst1;
    logic [31:0] fetch_inst2;
    logic [31:0] fetch_pc1;
    logic [31:0] fetch_pc2;
    logic [1:0]  issue_num;
    logic        issue_valid1;
    logic        issue_valid2;
    logic [31:0] issue_inst1;
    logic [31:0] issue_inst2;
    logic [31:0] issue_pc1;
    logic [31:0] issue_pc2;
    logic        ibuffer_full;
    logic        ibuffer_overflow;

    // Fetch side pushes whenever fetch_valid1 is high (no ready signal: space is
    // managed upstream via ibuffer_full); issue side pops issue_num entries that
    // are currently shown as valid.
    modport master (
        output flush, fetch_valid1, fetch_valid2, fetch_inst1, fetch_inst2,
               fetch_pc1, fetch_pc2, issue_num,
        input  issue_valid1, issue_valid2, issue_inst1, issue_inst2,
               issue_pc1, issue_pc2, ibuffer_full, ibuffer_overflow
    );

    modport slave (
        input  flush, fetch_valid1, fetch_valid2, fetch_inst1, fetch_inst2,
               fetch_pc1, fetch_pc2, issue_num,
        output issue_valid1, issue_valid2, issue_inst1, issue_inst2,
               issue_pc1, issue_pc2, ibuffer_full, ibuffer_overflow
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer: up to two pushes and (with IBUF_DUAL_POP_EN) two pops
// per cycle; without IBUF_DUAL_POP_EN only the head entry is exposed and popped.
module inst_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned FULL_THRESH = 6
) (
    input logic         clk,
    input logic         rst,
    inst_buffer_if.slave bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [31:0]   r_inst [DEPTH];
    logic [31:0]   r_pc   [DEPTH];

    logic [1:0]    w_req_n;
    logic [1:0]    w_pop_n;
    logic [1:0]    w_push_n;
    logic [1:0]    w_accept_n;
    logic [AW:0]   w_space;
    logic [AW:0]   w_free;
    logic [AW-1:0] w_tail1;
    logic          w_valid1;

    always_comb begin
        w_req_n = 2'd0;
`ifdef IBUF_DUAL_POP_EN
        case (bus.issue_num)
            2'd0:    w_req_n = 2'd0;
            2'd1:    w_req_n = 2'd1;
            default: w_req_n = 2'd2;
        endcase
`else
        w_req_n = (bus.issue_num != 2'd0) ? 2'd1 : 2'd0;
`endif
        w_pop_n  = ((AW+1)'(w_req_n) > r_count) ? r_count[1:0] : w_req_n;
        w_push_n = !bus.fetch_valid1 ? 2'd0 : (bus.fetch_valid2 ? 2'd2 : 2'd1);
        // Space is judged after this cycle's pop so a full buffer can still accept
        w_space    = DEPTH_C - (r_count - (AW+1)'(w_pop_n));
        w_accept_n = ((AW+1)'(w_push_n) > w_space) ? w_space[1:0] : w_push_n;
        w_tail1    = r_tail + AW'(1);
        w_free     = DEPTH_C - r_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_tail  <= r_tail + AW'(w_accept_n);
            r_count <= r_count - (AW+1)'(w_pop_n) + (AW+1)'(w_accept_n);
            if (w_accept_n != w_push_n) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; entries beyond count are never presented.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            if (w_accept_n != 2'd0) begin
                r_inst[r_tail] <= bus.fetch_inst1;
                r_pc[r_tail]   <= bus.fetch_pc1;
            end
            if (w_accept_n == 2'd2) begin
                r_inst[w_tail1] <= bus.fetch_inst2;
                r_pc[w_tail1]   <= bus.fetch_pc2;
            end
        end
    end

    assign w_valid1             = (r_count != '0);
    assign bus.issue_valid1     = w_valid1;
    assign bus.issue_inst1      = w_valid1 ? r_inst[r_head] : 32'd0;
    assign bus.issue_pc1        = w_valid1 ? r_pc[r_head]   : 32'd0;
    assign bus.ibuffer_full     = (32'(w_free) < FULL_THRESH);
    assign bus.ibuffer_overflow = r_overflow;

`ifdef IBUF_DUAL_POP_EN
    logic [AW-1:0] w_head1;
    logic          w_valid2;
    assign w_head1          = r_head + AW'(1);
    assign w_valid2         = (r_count >= (AW+1)'(2));
    assign bus.issue_valid2 = w_valid2;
    assign bus.issue_inst2  = w_valid2 ? r_inst[w_head1] : 32'd0;
    assign bus.issue_pc2    = w_valid2 ? r_pc[w_head1]   : 32'd0;
`else
    assign bus.issue_valid2 = 1'b0;
    assign bus.issue_inst2  = 32'd0;
    assign bus.issue_pc2    = 32'd0;
`endif
endmodule

// File: tb/tb_inst_buffer.sv
// Directed and random stimulus for inst_buffer, checked against a queue-based model.
module tb_inst_buffer;
    localparam int DEPTH       = 16;
    localparam int FULL_THRESH = 6;
`ifdef IBUF_DUAL_POP_EN
    localparam int MAX_POP = 2;
`else
    localparam int MAX_POP = 1;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    inst_buffer_if bus ();

    inst_buffer #(.DEPTH(DEPTH), .FULL_THRESH(FULL_THRESH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        exp_q[$];
    logic        exp_ovf;
    int          checks;
    int          failures;
    logic [31:0] next_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int          n;
        logic        ev1, ev2;
        logic [31:0] ei1, ep1, ei2, ep2;
        n   = exp_q.size();
        ev1 = (n >= 1);
        ev2 = (MAX_POP == 2) && (n >= 2);
        ei1 = ev1 ? exp_q[0].inst : 32'd0;
        ep1 = ev1 ? exp_q[0].pc   : 32'd0;
        ei2 = ev2 ? exp_q[1].inst : 32'd0;
        ep2 = ev2 ? exp_q[1].pc   : 32'd0;
        chk({tag, ".valid1"}, 32'(bus.issue_valid1), 32'(ev1));
        chk({tag, ".valid2"}, 32'(bus.issue_valid2), 32'(ev2));
        chk({tag, ".inst1"}, bus.issue_inst1, ei1);
        chk({tag, ".pc1"}, bus.issue_pc1, ep1);
        chk({tag, ".inst2"}, bus.issue_inst2, ei2);
        chk({tag, ".pc2"}, bus.issue_pc2, ep2);
        chk({tag, ".full"}, 32'(bus.ibuffer_full), 32'((DEPTH - n) < FULL_THRESH));
        chk({tag, ".ovf"}, 32'(bus.ibuffer_overflow), 32'(exp_ovf));
    endtask

    task automatic set_idle();
        bus.flush        = 1'b0;
        bus.fetch_valid1 = 1'b0;
        bus.fetch_valid2 = 1'b0;
        bus.fetch_inst1  = $urandom;
        bus.fetch_inst2  = $urandom;
        bus.fetch_pc1    = $urandom;
        bus.fetch_pc2    = $urandom;
        bus.issue_num    = 2'd0;
    endtask

    task automatic model_push(input logic [31:0] inst, input logic [31:0] pc);
        ent_t e;
        e.inst = inst;
        e.pc   = pc;
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic drive(input logic f, input logic v1, input logic v2,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic [31:0] i2, input logic [31:0] p2,
                         input logic [1:0] num, input string tag);
        int want, pop;
        bus.flush        = f;
        bus.fetch_valid1 = v1;
        bus.fetch_valid2 = v2;
        bus.fetch_inst1  = i1;
        bus.fetch_pc1    = p1;
        bus.fetch_inst2  = i2;
        bus.fetch_pc2    = p2;
        bus.issue_num    = num;
        @(posedge clk);
        if (f) begin
            exp_q.delete();
        end else begin
            want = (int'(num) > MAX_POP) ? MAX_POP : int'(num);
            pop  = (want > exp_q.size()) ? exp_q.size() : want;
            for (int k = 0; k < pop; k++) void'(exp_q.pop_front());
            if (v1) model_push(i1, p1);
            if (v1 && v2) model_push(i2, p2);
        end
        #1;
        set_idle();
        check_all(tag);
    endtask

    task automatic push2(input logic [1:0] num, input string tag);
        drive(1'b0, 1'b1, 1'b1, $urandom, next_pc, $urandom, next_pc + 32'd4, num, tag);
        next_pc = next_pc + 32'd8;
    endtask

    task automatic push1(input logic [1:0] num, input string tag);
        drive(1'b0, 1'b1, 1'b0, $urandom, next_pc, $urandom, $urandom, num, tag);
        next_pc = next_pc + 32'd4;
    endtask

    task automatic pop_only(input logic [1:0] num, input string tag);
        drive(1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, num, tag);
    endtask

    task automatic do_reset(input string tag);
        rst              = 1'b1;
        bus.flush        = 1'($urandom_range(0, 1));
        bus.fetch_valid1 = 1'b1;
        bus.fetch_valid2 = 1'b1;
        bus.issue_num    = 2'($urandom_range(0, 3));
        @(posedge clk);
        exp_q.delete();
        exp_ovf = 1'b0;
        next_pc = 32'h0000_1000;
        #1;
        rst = 1'b0;
        set_idle();
        check_all(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_ovf  = 1'b0;
        next_pc  = 32'h0000_1000;
        rst      = 1'b1;
        set_idle();
        @(negedge clk);

        // Reset values
        do_reset("reset");
        chk("reset.valid1_const", 32'(bus.issue_valid1), 32'd0);
        chk("reset.full_const", 32'(bus.ibuffer_full), 32'd0);

        // First dual push becomes visible the next cycle
        drive(1'b0, 1'b1, 1'b1, 32'h2401_0001, 32'hBFC0_0000, 32'h2402_0002, 32'hBFC0_0004,
              2'd0, "first");
        chk("first.pc1_const", bus.issue_pc1, 32'hBFC0_0000);
        chk("first.inst1_const", bus.issue_inst1, 32'h2401_0001);
        chk("first.pc2_const", bus.issue_pc2, (MAX_POP == 2) ? 32'hBFC0_0004 : 32'd0);

        // Full threshold
        do_reset("fill.reset");
        for (int k = 0; k < 5; k++) push2(2'd0, "fill");
        chk("fill.full_at10", 32'(bus.ibuffer_full), 32'd0);
        push2(2'd0, "fill6");
        chk("fill.full_at12", 32'(bus.ibuffer_full), 32'd1);
        chk("fill.ovf_at12", 32'(bus.ibuffer_overflow), 32'd0);

        // Push into a full buffer with a single pop: one accepted, one dropped
        push2(2'd0, "fill7");
        push2(2'd0, "fill8");
        push2(2'd1, "ovf_push");
        chk("ovf.set", 32'(bus.ibuffer_overflow), 32'd1);
        chk("ovf.count_full", 32'(exp_q.size() == DEPTH && bus.ibuffer_full), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, "ovf_flush");
        chk("ovf.sticky_flush", 32'(bus.ibuffer_overflow), 32'd1);

        // Two-entry read across the wrap point
        do_reset("wrap.reset");
        for (int k = 0; k < 8; k++) push2(2'd0, "wrap.fill");
        for (int k = 0; k < 15; k++) pop_only(2'd1, "wrap.pop");
        chk("wrap.head15_pc", bus.issue_pc1, 32'h0000_103C);
        push2(2'd0, "wrap.push");
        pop_only(2'd2, "wrap.pop2");
        chk("wrap.pc1_after", bus.issue_pc1, (MAX_POP == 2) ? 32'h0000_1044 : 32'h0000_1040);

        // Flush together with push and pop
        do_reset("flush.reset");
        push2(2'd0, "flush.fill");
        push2(2'd0, "flush.fill");
        push1(2'd0, "flush.fill");
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_0000, 32'hDEAD_BEEF, 32'hCAFE_0004,
              2'd2, "flush");
        chk("flush.valid1", 32'(bus.issue_valid1), 32'd0);
        chk("flush.full", 32'(bus.ibuffer_full), 32'd0);
        pop_only(2'd0, "flush.after");

        // Drain four entries with issue_num=2 every cycle
        do_reset("drain.reset");
        push2(2'd0, "drain.fill");
        push2(2'd0, "drain.fill");
        for (int k = 0; k < 4; k++) pop_only(2'd2, "drain");
        chk("drain.empty", 32'(bus.issue_valid1), 32'd0);

        // Random traffic, biased towards pushing so the full region is exercised
        do_reset("rand.reset");
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rand.rst");
            end else begin
                drive(($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 2) != 0),
                      $urandom, $urandom, $urandom, $urandom,
                      2'($urandom_range(0, 3)), "rand");
            end
        end

        do_reset("final.reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Instruction buffer (ibuffer) sitting between the icache fetch return and the dual-issue stage.
- Accepts up to two fetched instructions plus their PCs per cycle, stores them in a circular FIFO, and presents the two oldest entries to issue.
- Generates `ibuffer_full` back to pc_reg so fetch requests stop before the FIFO can overflow.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- FULL_THRESH, 6, `ibuffer_full` is asserted when free slots (DEPTH - count) < FULL_THRESH. Covers in-flight fetch latency.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pipeline flush; discards all entries.
- fetch_valid1  in  1  inst slot 1 returned by icache this cycle.
- fetch_valid2  in  1  inst slot 2 returned; ignored unless fetch_valid1=1.
- fetch_inst1  in  32  instruction at fetch_pc1.
- fetch_inst2  in  32  instruction at fetch_pc2.
- fetch_pc1  in  32  address of slot 1.
- fetch_pc2  in  32  address of slot 2 (normally fetch_pc1+4).
- issue_num  in  2  entries consumed by issue this cycle (0, 1, 2; 3 treated as 2).
- issue_valid1  out  1  head entry present.
- issue_valid2  out  1  head+1 entry present.
- issue_inst1  out  32  head instruction; 0 when issue_valid1=0.
- issue_inst2  out  32  head+1 instruction; 0 when issue_valid2=0.
- issue_pc1  out  32  head PC; 0 when invalid.
- issue_pc2  out  32  head+1 PC; 0 when invalid.
- ibuffer_full  out  1  backpressure to pc_reg.
- ibuffer_overflow  out  1  sticky error: a push was dropped for lack of space.

Behaviour:
- State: head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits), storage of DEPTH x {inst, pc}.
- Reset (rst=1 at edge): head=tail=count=0, ibuffer_overflow=0. Storage need not be cleared. Outputs after reset:
  - issue_valid1=0, issue_valid2=0.
  - issue data=0.
  - ibuffer_full=0.
- Outputs are combinational from registered state only; no fetch-to-issue bypass.
  - issue_valid1 = (count>=1).
  - issue_valid2 = (count>=2).
- Pop: pop_n = min(issue_num clamped to 2, count). head += pop_n; count -= pop_n.
- Push:
  - push_n = 0 if fetch_valid1=0.
  - push_n = 1 if only fetch_valid1=1.
  - push_n = 2 if both are 1.
  - Slot 1 is written at tail and slot 2 at tail+1, with wrap.
- Simultaneous push and pop: space is checked against the post-pop count.
  - Accepted = min(push_n, DEPTH - (count - pop_n)); slot 1 has priority.
  - tail += accepted; count = count - pop_n + accepted.
- If accepted < push_n, the excess is dropped and ibuffer_overflow is set to 1 until rst. The overflow is not cleared by flush.
- Empty: issue_num is ignored; no underflow.
- Full (count=DEPTH): pushes are dropped unless a pop the same cycle frees space.
- ibuffer_full = ((DEPTH - count) < FULL_THRESH). It is derived from registered count, so it is glitch-free and reflects state one cycle after the push.
- Flush (flush=1, rst=0): head=tail=count=0 next cycle. Same-cycle pushes and pops are discarded, since the fetch data belongs to the wrong path.
- rst has priority over flush.
- Reset or flush mid-operation: all in-flight entries are lost; no partial state survives.
- Pointer wrap: a two-entry write or read spanning DEPTH-1 to 0 is handled per slot modulo DEPTH.

Optional Feature:
- Macro: IBUF_DUAL_POP_EN.
- Defined: up to two pops per cycle as above.
- Undefined:
  - issue_num is clamped to 1, so at most one pop per cycle.
  - issue_valid2 is forced to 0; issue_inst2/issue_pc2 are forced to 0.
  - The storage and push path are unchanged (two pushes per cycle still allowed).

Test Plan:
- Reset, then push {0x24010001@0xBFC00000, 0x24020002@0xBFC00004} with issue_num=0. Next cycle: valid1=valid2=1, pc1=0xBFC00000, pc2=0xBFC00004, inst1=0x24010001.
- Fill with 5 dual pushes (10 entries), DEPTH=16, FULL_THRESH=6, no pops. ibuffer_full=0 at count=10 and 1 after the 6th push (count=12); overflow stays 0.
- Count=16 with a dual push and issue_num=1 in the same cycle. One entry accepted, one dropped; count=16; ibuffer_overflow=1 and stays 1 across a following flush.
- Head at 15 with 3 entries; issue_num=2. pc1/pc2 come from slots 15 and 0; next head=1, count=1.
- Count=5, flush=1 together with a dual push and issue_num=2. Next cycle: count=0, valid1=0, ibuffer_full=0; the pushed data never appears.
- With IBUF_DUAL_POP_EN undefined: 4 entries and issue_num=2 per cycle drain one per cycle over 4 cycles; issue_valid2 is always 0.
